// File: rtl/cache_controller_pkg.sv
// cache_defs: shared definitions for the read cache (FSM states, address split).
// Latency: n/a (types, constants and a word-select helper only).
// Backpressure: n/a.
package cache_defs;

  localparam int ADDR_W   = 18;                    // significant address bits
  localparam int INDEX_W  = 6;                     // 64 sets
  localparam int TAG_W    = ADDR_W - INDEX_W - 3;  // 9
  localparam int WSEL_BIT = 2;                     // word within 64-bit block
  localparam int IDX_LSB  = 3;
  localparam int TAG_LSB  = IDX_LSB + INDEX_W;     // 9

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR      = 2'd2
  } state_e;

  // Pick the 32-bit word out of a block: [31:0] even word, [63:32] odd word.
  function automatic logic [31:0] sel_word(input logic [63:0] blk, input logic odd);
    return odd ? blk[63:32] : blk[31:0];
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// cache_controller_if: MEM-stage request bus plus SRAM-controller bus of the read cache.
// Latency: n/a (wiring only).
// Backpressure: ready low stalls the MEM stage; sram_ready completes an SRAM access.
// Ports: slave = cache side, master = MEM stage / SRAM controller side.
interface cache_controller_if;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read_en;
  logic        sram_write_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport slave (
    input  address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
    output rdata, ready, sram_address, sram_wdata, sram_read_en, sram_write_en
  );

  modport master (
    output address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
    input  rdata, ready, sram_address, sram_wdata, sram_read_en, sram_write_en
  );
endinterface

// File: rtl/cache_way_array.sv
// cache_way_array: one way of the cache -- valid bits, tags and 64-bit data blocks.
// Latency: asynchronous read by index; fill/invalidate take effect at the next posedge.
// Backpressure: none; writes are accepted every cycle.
// Ports: clk_i/rst_i, index_i (read and write index), valid_o/tag_o/data_o (read),
//        fill_i/fill_tag_i/fill_data_i (line fill), inval_i (clear valid at index_i).
module cache_way_array #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] index_i,
  output logic               valid_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [63:0]        data_o,
  input  logic               fill_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  logic [63:0]        fill_data_i,
  input  logic               inval_i
);
  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [63:0]      data_q [SETS];

  assign valid_o = valid_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign data_o  = data_q[index_i];

  // Only the valid bits need reset; tag/data are qualified by valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[index_i] <= 1'b1;
    end else if (inval_i) begin
      valid_q[index_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[index_i]  <= fill_tag_i;
      data_q[index_i] <= fill_data_i;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// cache_controller: 2-way, 64-set, write-through, no-write-allocate read cache with 1-bit LRU.
// Latency: read hit completes in the request cycle; read miss / write take 1 + SRAM latency.
// Backpressure: ready=0 while a miss or write is outstanding; MEM stage holds its request.
// Ports: clk, rst (sync, active high), bus (slave modport: MEM request side + SRAM side).
module cache_controller
  import cache_defs::*;
#(
  parameter int P_INDEX_W = INDEX_W,
  parameter int P_TAG_W   = TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  cache_controller_if.slave  bus
);
  localparam int SETS = 1 << P_INDEX_W;

  state_e            state_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic [SETS-1:0]   lru_q;      // 1: way0 is MRU (victim way1); 0: victim way0

  logic [P_INDEX_W-1:0] index;
  logic [P_TAG_W-1:0]   tag;
  logic                 word_sel;
  logic                 wr_req;
  logic                 rd_req;

  logic              valid0, valid1;
  logic [P_TAG_W-1:0] tag0, tag1;
  logic [63:0]       data0, data1;
  logic              hit0, hit1, hit;
  logic              victim_way;
  logic              fill_done;
  logic              fill0, fill1;
  logic              inval0, inval1;

  assign index    = bus.address[IDX_LSB +: P_INDEX_W];
  assign tag      = bus.address[IDX_LSB + P_INDEX_W +: P_TAG_W];
  assign word_sel = bus.address[WSEL_BIT];

  // A simultaneous read and write is treated as a write.
  assign wr_req = bus.MEM_W_EN;
  assign rd_req = bus.MEM_R_EN & ~bus.MEM_W_EN;

  assign hit0 = valid0 && (tag0 == tag);
  assign hit1 = valid1 && (tag1 == tag);
  assign hit  = hit0 | hit1;

  assign victim_way = lru_q[index];
  assign fill_done  = (state_q == RD_MISS) && bus.sram_ready;
  assign fill0      = fill_done && !victim_way && !rst;
  assign fill1      = fill_done &&  victim_way && !rst;

  // Write-through without allocate: a write hit just drops the stale line.
  assign inval0 = (state_q == IDLE) && wr_req && hit0;
  assign inval1 = (state_q == IDLE) && wr_req && hit1;

  cache_way_array #(.INDEX_W(P_INDEX_W), .TAG_W(P_TAG_W)) u_way0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .index_i     (index),
    .valid_o     (valid0),
    .tag_o       (tag0),
    .data_o      (data0),
    .fill_i      (fill0),
    .fill_tag_i  (tag),
    .fill_data_i (bus.sram_rdata),
    .inval_i     (inval0)
  );

  cache_way_array #(.INDEX_W(P_INDEX_W), .TAG_W(P_TAG_W)) u_way1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .index_i     (index),
    .valid_o     (valid1),
    .tag_o       (tag1),
    .data_o      (data1),
    .fill_i      (fill1),
    .fill_tag_i  (tag),
    .fill_data_i (bus.sram_rdata),
    .inval_i     (inval1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      lru_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_req) begin
            state_q <= WR;
            wr_en_q <= 1'b1;
          end else if (rd_req) begin
            if (hit) begin
              lru_q[index] <= hit0;
            end else begin
              state_q <= RD_MISS;
              rd_en_q <= 1'b1;
            end
          end
        end
        RD_MISS: begin
          if (bus.sram_ready) begin
            state_q      <= IDLE;
            rd_en_q      <= 1'b0;
            lru_q[index] <= ~victim_way;  // freshly filled way becomes MRU
          end
        end
        WR: begin
          if (bus.sram_ready) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.ready = 1'b1;
    bus.rdata = 32'h0;
    case (state_q)
      IDLE: begin
        bus.ready = !wr_req && (!rd_req || hit);
        if (rd_req && hit) begin
          bus.rdata = sel_word(hit1 ? data1 : data0, word_sel);
        end
      end
      RD_MISS: begin
        bus.ready = bus.sram_ready;
        if (bus.sram_ready) begin
          bus.rdata = sel_word(bus.sram_rdata, word_sel);
        end
      end
      WR: begin
        bus.ready = bus.sram_ready;
      end
      default: begin
        bus.ready = 1'b1;
      end
    endcase
  end

  always_comb begin
    bus.sram_address = 32'h0;
    bus.sram_wdata   = 32'h0;
    if (state_q == RD_MISS) begin
      bus.sram_address = {bus.address[31:3], 3'b000};
    end else if (state_q == WR) begin
      bus.sram_address = bus.address;
      bus.sram_wdata   = bus.wdata;
    end
  end

  assign bus.sram_read_en  = rd_en_q;
  assign bus.sram_write_en = wr_en_q;

endmodule
